// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-client memory arbiter.
// Imported by the arbiter top and its winner-pick helper.
package mem_arb_pkg;

  localparam int ADDR_W_D = 10;
  localparam int DATA_W_D = 20;

  localparam logic CLI0 = 1'b0;
  localparam logic CLI1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_GAP  = 2'b10
  } arb_st_e;

  function automatic logic [1:0] cli_onehot(
    input logic id
  );
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way round-robin winner selection with optional
// write-back lock that keeps the last writer on the port.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       lock_en,
  input  logic       last_was_write,
  output logic       any,
  output logic       win
);

  logic w_keep;

  always_comb begin
    w_keep = lock_en & last_was_write & req[rr_last];
    any    = |req;
    win    = CLI0;
    priority case (1'b1)
      w_keep:         win = rr_last;
      (req == 2'b11): win = ~rr_last;
      req[1]:         win = CLI1;
      default:        win = CLI0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between two cache clients:
// round-robin grant, optional write-back lock, watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_D,
  parameter int DATA_W  = DATA_W_D,
  parameter int LOCK_WB = 1,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c0_req,
  input  logic              c0_rw,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic [DATA_W-1:0] c0_rdata,
  output logic              c0_ready,
  input  logic              c1_req,
  input  logic              c1_rw,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic              c1_ready,
  output logic              mem_req,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  arb_st_e r_state;
  arb_st_e w_nxt;

  logic              w_any;
  logic              w_win;
  logic              w_start;
  logic              w_done;
  logic              w_to;
  logic              w_expire;
  logic [DATA_W-1:0] w_rd;

  logic              r_owner;
  logic              r_rr_last;
  logic              r_lww;
  logic [WD_W-1:0]   r_wd;
  logic              r_mem_req;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [1:0]        r_gnt;
  logic              r_terr;
  logic              r_c0_ready;
  logic              r_c1_ready;
  logic [DATA_W-1:0] r_c0_rdata;
  logic [DATA_W-1:0] r_c1_rdata;

  arb_rr_pick u_pick (
    .req            ({c1_req, c0_req}),
    .rr_last        (r_rr_last),
    .lock_en        (LOCK_WB != 0),
    .last_was_write (r_lww),
    .any            (w_any),
    .win            (w_win)
  );

  assign w_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt   = r_state;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_to    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_nxt   = ST_BUSY;
          w_start = 1'b1;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          w_nxt  = ST_GAP;
          w_done = 1'b1;
        end else if (w_expire) begin
          w_nxt  = ST_GAP;
          w_done = 1'b1;
          w_to   = 1'b1;
        end
      end
      ST_GAP:  w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  // writes echo the latched data back to the client
  assign w_rd = w_to     ? '0 :
                r_mem_rw ? r_mem_wdata : mem_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= CLI0;
      r_rr_last   <= CLI1;
      r_lww       <= 1'b0;
      r_wd        <= '0;
      r_mem_req   <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_gnt       <= 2'b00;
      r_terr      <= 1'b0;
      r_c0_ready  <= 1'b0;
      r_c1_ready  <= 1'b0;
      r_c0_rdata  <= '0;
      r_c1_rdata  <= '0;
    end else begin
      r_c0_ready <= 1'b0;
      r_c1_ready <= 1'b0;
      if (w_start) begin
        r_owner     <= w_win;
        r_mem_req   <= 1'b1;
        r_gnt       <= cli_onehot(w_win);
        r_mem_rw    <= w_win ? c1_rw    : c0_rw;
        r_mem_addr  <= w_win ? c1_addr  : c0_addr;
        r_mem_wdata <= w_win ? c1_wdata : c0_wdata;
        r_wd        <= '0;
      end
      if (r_state == ST_BUSY && TIMEOUT != 0)
        r_wd <= r_wd + WD_W'(1);
      if (w_done) begin
        r_mem_req <= 1'b0;
        r_gnt     <= 2'b00;
        r_rr_last <= r_owner;
        r_lww     <= r_mem_rw;
        if (w_to) r_terr <= 1'b1;
        if (r_owner) begin
          r_c1_ready <= 1'b1;
          r_c1_rdata <= w_rd;
        end else begin
          r_c0_ready <= 1'b1;
          r_c0_rdata <= w_rd;
        end
      end
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_rw      = r_mem_rw;
  assign mem_addr    = r_mem_addr;
  assign mem_data_in = r_mem_wdata;
  assign grant       = r_gnt;
  assign timeout_err = r_terr;
  assign c0_ready    = r_c0_ready;
  assign c1_ready    = r_c1_ready;
  assign c0_rdata    = r_c0_rdata;
  assign c1_rdata    = r_c1_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random
// traffic checked against a transaction-level model.
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          cq [2];
  logic          crw[2];
  logic [AW-1:0] ca [2];
  logic [DW-1:0] cw [2];
  logic          mem_ready;
  logic [DW-1:0] mem_data_out;

  logic [DW-1:0] lk_rd0, lk_rd1, nl_rd0, nl_rd1;
  logic          lk_rdy0, lk_rdy1, nl_rdy0, nl_rdy1;
  logic          lk_mreq, lk_mrw, nl_mreq, nl_mrw;
  logic [AW-1:0] lk_madr, nl_madr;
  logic [DW-1:0] lk_mdin, nl_mdin;
  logic [1:0]    lk_gnt, nl_gnt;
  logic          lk_terr, nl_terr;

  bit sel = 1'b0;

  logic [DW-1:0] o_rd[2];
  logic [1:0]    o_rdy;
  logic          o_mreq, o_mrw, o_terr;
  logic [AW-1:0] o_madr;
  logic [DW-1:0] o_mdin;
  logic [1:0]    o_gnt;

  assign o_rd[0] = sel ? nl_rd0 : lk_rd0;
  assign o_rd[1] = sel ? nl_rd1 : lk_rd1;
  assign o_rdy   = sel ? {nl_rdy1, nl_rdy0} : {lk_rdy1, lk_rdy0};
  assign o_mreq  = sel ? nl_mreq : lk_mreq;
  assign o_mrw   = sel ? nl_mrw  : lk_mrw;
  assign o_madr  = sel ? nl_madr : lk_madr;
  assign o_mdin  = sel ? nl_mdin : lk_mdin;
  assign o_gnt   = sel ? nl_gnt  : lk_gnt;
  assign o_terr  = sel ? nl_terr : lk_terr;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW),
                .LOCK_WB(1), .TIMEOUT(8)) u_lk (
    .clk(clk), .rst(rst),
    .c0_req(cq[0]), .c0_rw(crw[0]), .c0_addr(ca[0]),
    .c0_wdata(cw[0]), .c0_rdata(lk_rd0), .c0_ready(lk_rdy0),
    .c1_req(cq[1]), .c1_rw(crw[1]), .c1_addr(ca[1]),
    .c1_wdata(cw[1]), .c1_rdata(lk_rd1), .c1_ready(lk_rdy1),
    .mem_req(lk_mreq), .mem_rw(lk_mrw), .mem_addr(lk_madr),
    .mem_data_in(lk_mdin), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .grant(lk_gnt),
    .timeout_err(lk_terr)
  );

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW),
                .LOCK_WB(0), .TIMEOUT(0)) u_nl (
    .clk(clk), .rst(rst),
    .c0_req(cq[0]), .c0_rw(crw[0]), .c0_addr(ca[0]),
    .c0_wdata(cw[0]), .c0_rdata(nl_rd0), .c0_ready(nl_rdy0),
    .c1_req(cq[1]), .c1_rw(crw[1]), .c1_addr(ca[1]),
    .c1_wdata(cw[1]), .c1_rdata(nl_rd1), .c1_ready(nl_rdy1),
    .mem_req(nl_mreq), .mem_rw(nl_mrw), .mem_addr(nl_madr),
    .mem_data_in(nl_mdin), .mem_data_out(mem_data_out),
    .mem_ready(mem_ready), .grant(nl_gnt),
    .timeout_err(nl_terr)
  );

  // reference model state
  int            m_rr;
  bit            m_lww, m_terr, m_lock;
  int            m_to;
  logic [DW-1:0] marr[1024];
  bit            rnd_on;
  logic [1:0]    obs_gnt;

  int n_tot = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int c, input logic rw,
                        input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    cq[c]  = 1'b1;
    crw[c] = rw;
    ca[c]  = a;
    cw[c]  = d;
  endtask

  task automatic new_req(input int c);
    setreq(c, 1'($urandom_range(0, 1)),
           AW'($urandom_range(0, 15)), DW'($urandom));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    cq[0]     = 1'b0;
    cq[1]     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    m_rr   = 1;
    m_lww  = 1'b0;
    m_terr = 1'b0;
    m_lock = (sel == 1'b0);
    m_to   = sel ? 0 : 8;
  endtask

  // Called in IDLE with at least one request up; returns in GAP.
  task automatic serve(input int lat, input bit hold,
                       output int w);
    logic [1:0]    rq, eg;
    logic          erw;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed, er;
    bit            tmo;
    int            nb, l;
    rq = {cq[1], cq[0]};
    if (m_lock && m_lww && rq[m_rr]) w = m_rr;
    else if (rq == 2'b11)            w = 1 - m_rr;
    else                             w = rq[1] ? 1 : 0;
    l   = 1 - w;
    eg  = (w == 1) ? 2'b10 : 2'b01;
    erw = crw[w];
    ea  = ca[w];
    ed  = cw[w];
    step();
    obs_gnt = o_gnt;
    check("grant", o_gnt, eg);
    check("mem_rw", o_mrw, erw);
    check("mem_addr", o_madr, ea);
    check("mem_din", o_mdin, ed);
    tmo = (m_to != 0) && (lat >= m_to);
    nb  = tmo ? m_to : lat + 1;
    for (int k = 0; k < nb; k++) begin
      check("busy", {o_mreq, o_gnt, o_rdy},
            {1'b1, eg, 2'b00});
      if (rnd_on && k == 0 && !cq[l] && $urandom_range(0, 1) == 1)
        new_req(l);
      if (!tmo && k == lat) begin
        mem_ready    = 1'b1;
        mem_data_out = erw ? DW'($urandom) : marr[ea];
      end else begin
        mem_ready    = 1'b0;
        mem_data_out = DW'($urandom);
      end
      step();
    end
    er = tmo ? '0 : (erw ? ed : marr[ea]);
    check("ready", o_rdy, eg);
    check("rdata", o_rd[w], er);
    check("gap_port", {o_mreq, o_gnt}, 3'b000);
    if (!tmo && erw) marr[ea] = ed;
    m_rr  = w;
    m_lww = erw;
    if (tmo) m_terr = 1'b1;
    check("terr", o_terr, m_terr);
    mem_ready    = hold;
    mem_data_out = DW'($urandom);
  endtask

  int w;

  initial begin
    cq[0] = 0; cq[1] = 0; crw[0] = 0; crw[1] = 0;
    ca[0] = 0; ca[1] = 0; cw[0] = 0; cw[1] = 0;
    mem_ready    = 1'b0;
    mem_data_out = '0;
    rnd_on       = 1'b0;
    for (int i = 0; i < 1024; i++) marr[i] = DW'($urandom);

    // reset values, both instances
    sel = 1'b0;
    do_reset();
    check("rst_lk", {lk_mreq, lk_gnt, lk_rdy1, lk_rdy0, lk_terr,
                     lk_mrw, lk_madr}, 0);
    check("rst_nl", {nl_mreq, nl_gnt, nl_rdy1, nl_rdy0, nl_terr,
                     nl_mrw, nl_madr}, 0);

    // single read
    marr[10'h0A4] = 20'hABCDE;
    setreq(0, 1'b0, 10'h0A4, '0);
    serve(3, 1'b0, w);
    check("sr_gnt", obs_gnt, 2'b01);
    check("sr_rdata", o_rd[0], 20'hABCDE);
    check("sr_c1rdy", o_rdy[1], 1'b0);
    cq[0] = 1'b0;
    step();
    check("sr_after", {o_mreq, o_rdy}, 0);

    // contention from reset
    do_reset();
    setreq(0, 1'b0, 10'h010, '0);
    setreq(1, 1'b0, 10'h011, '0);
    serve(2, 1'b0, w);
    check("cont_a", obs_gnt, 2'b01);
    setreq(0, 1'b0, 10'h012, '0);
    step();
    serve(1, 1'b0, w);
    check("cont_b", obs_gnt, 2'b10);
    setreq(1, 1'b0, 10'h013, '0);
    step();
    serve(0, 1'b0, w);
    check("cont_c", obs_gnt, 2'b01);

    // write-back lock, then the same without lock
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_reset();
      setreq(1, 1'b1, 10'h3E2, 20'h12345);
      serve(2, 1'b0, w);
      check("wb_wr", obs_gnt, 2'b10);
      setreq(1, 1'b0, 10'h3E2, '0);
      setreq(0, 1'b0, 10'h100, '0);
      step();
      serve(1, 1'b0, w);
      check("wb_2nd", obs_gnt, (s == 0) ? 2'b10 : 2'b01);
      cq[w] = 1'b0;
      step();
      serve(1, 1'b0, w);
      check("wb_3rd", obs_gnt, (s == 0) ? 2'b01 : 2'b10);
      check("wb_rd", o_rd[1], 20'h12345);
    end

    // watchdog
    sel = 1'b0;
    do_reset();
    setreq(0, 1'b0, 10'h055, '0);
    serve(20, 1'b0, w);
    check("to_rdata", o_rd[0], 0);
    check("to_err", o_terr, 1'b1);
    setreq(0, 1'b0, 10'h0A4, '0);
    step();
    serve(2, 1'b0, w);
    check("to_next", o_rd[0], 20'hABCDE);
    check("to_sticky", o_terr, 1'b1);

    // asynchronous reset two cycles into a c1 access
    do_reset();
    setreq(1, 1'b0, 10'h001, '0);
    step();
    step();
    step();
    check("pre_rst", {o_mreq, o_gnt}, 3'b110);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid", {o_mreq, o_gnt, o_rdy, o_terr}, 0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    m_rr   = 1;
    m_lww  = 1'b0;
    m_terr = 1'b0;
    setreq(0, 1'b0, 10'h002, '0);
    setreq(1, 1'b0, 10'h003, '0);
    serve(0, 1'b0, w);
    check("rst_cont", obs_gnt, 2'b01);

    // mem_ready held three cycles, stale req left up in GAP
    do_reset();
    setreq(0, 1'b0, 10'h020, '0);
    serve(1, 1'b1, w);
    step();
    check("stale_a", {o_mreq, o_rdy}, 0);
    cq[0] = 1'b0;
    step();
    check("stale_b", {o_mreq, o_rdy}, 0);
    mem_ready = 1'b0;

    // random traffic on both instances
    rnd_on = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      do_reset();
      new_req(0);
      for (int n = 0; n < 150; n++) begin
        serve($urandom_range(0, 10), 1'($urandom_range(0, 1)), w);
        if ($urandom_range(0, 1) == 1) new_req(w);
        else cq[w] = 1'b0;
        if (!cq[1 - w] && $urandom_range(0, 3) == 0) new_req(1 - w);
        step();
        check("idle", {o_mreq, o_rdy}, 0);
        mem_ready = 1'($urandom_range(0, 1));
        while (!cq[0] && !cq[1]) begin
          if ($urandom_range(0, 2) != 0) begin
            new_req($urandom_range(0, 1));
          end else begin
            step();
            check("idle_stay", {o_mreq, o_gnt}, 0);
          end
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one main-memory port between two cache clients, for example an instruction cache and a data cache, that use the existing mem_req/mem_rw/mem_addr/mem_data_in/mem_data_out/mem_ready handshake. It sits between the caches and the memory model and presents the same handshake on both faces, so each cache connects unmodified. Arbitration is round-robin. An optional lock keeps a dirty-line write-back and its following allocate read atomic. A watchdog reports a memory that never answers.

Parameters:
ADDR_W, 10, address width (tag+index+offset as used by the cache)
DATA_W, 20, data word width
LOCK_WB, 1, 1 = the client that just completed a write keeps the grant if it requests again in the next arbitration slot
TIMEOUT, 64, BUSY cycles before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
c0_req  in  1  client 0 request; held high with stable rw/addr/wdata until c0_ready
c0_rw  in  1  1 = write, 0 = read
c0_addr  in  ADDR_W  client 0 address
c0_wdata  in  DATA_W  client 0 write data
c0_rdata  out  DATA_W  read data, valid while c0_ready=1
c0_ready  out  1  one-cycle completion pulse
c1_req, c1_rw, c1_addr, c1_wdata, c1_rdata, c1_ready  same as the c0 group, for client 1
mem_req  out  1  memory request
mem_rw  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_data_in  out  DATA_W  memory write data
mem_data_out  in  DATA_W  memory read data
mem_ready  in  1  memory completion
grant  out  2  one-hot owner of the memory port; 00 when idle
timeout_err  out  1  sticky; cleared only by rst

Behaviour:
- Reset (asynchronous, any state, including mid-transaction) sets:
  - all outputs to 0;
  - state to IDLE;
  - rr_last to 1, so client 0 has priority first;
  - the watchdog counter to 0.
  - Any in-flight memory access is abandoned. No ready pulse is issued.
- States and transitions:
  - IDLE → BUSY when any cN_req=1. Otherwise stay in IDLE.
  - BUSY → GAP on mem_ready, or on a watchdog expiry.
  - GAP → IDLE unconditionally.
- IDLE:
  - Winner selection:
    - Only one requester: it wins.
    - Both requesting: the client other than rr_last wins.
    - Override: if LOCK_WB=1, last_was_write=1 and c[rr_last]_req=1, rr_last wins.
  - On the entry edge into BUSY, latch the winner's rw/addr/wdata into mem_rw/mem_addr/mem_data_in, set mem_req=1, set grant, and clear the watchdog.
- BUSY:
  - Memory outputs stay stable from the latch; client inputs are ignored.
  - Watchdog increments each cycle.
  - On the first sampled mem_ready=1:
    - cW_ready=1 for exactly one cycle (the GAP cycle);
    - cW_rdata = mem_data_out for reads, or the latched wdata for writes;
    - mem_req=0, grant=00;
    - rr_last=W, last_was_write=mem_rw;
    - go to GAP.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without mem_ready:
    - same as above, but cW_rdata=0 and timeout_err=1.
- GAP:
  - Exactly one cycle. Requests are ignored, because the client still shows its stale req while it consumes ready.
  - Next edge → IDLE.
  - Non-winner ready outputs stay 0 in every state.
- Latency: req sampled in IDLE at cycle t → mem_req high at t+1. If mem_ready is first sampled at cycle t+k, cW_ready is high at t+k+1 and a new arbitration happens at t+k+2.
  - Minimum turnaround per access is therefore 3 cycles plus memory latency.
- mem_ready outside BUSY is ignored. A level-held mem_ready completes only one transaction per grant.
- A client dropping req while in BUSY does not cancel the access; it still gets a ready pulse.
- The rr_last / last_was_write update is a single-bit toggle. There is no counter wrap other than the watchdog, which saturates by leaving BUSY.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'b00, BUSY=2'b01, GAP=2'b10);
  - client-id constants CLI0=0, CLI1=1;
  - default ADDR_W/DATA_W.
- Sub-module arb_rr_pick: combinational 2-way winner selection.
  - Inputs: req[1:0], rr_last, lock_en, last_was_write.
  - Outputs: any, win.
- The FSM, datapath latches and watchdog stay in mem_arbiter.

Test Plan:
- Single read: c0 requests a read of addr 0x0A4; memory answers mem_ready after 3 cycles with 0xABCDE → mem_addr=0x0A4, mem_rw=0, grant=01; c0_ready pulses for one cycle with c0_rdata=0xABCDE; c1_ready stays 0.
- Contention: c0 and c1 both request from reset → c0 served first, then c1, then c0 again while both keep requesting; grant alternates 01,10,01.
- Write-back lock (LOCK_WB=1):
  - Stimulus: c1 writes 0x12345 to 0x3E2, then immediately re-requests a read of 0x3E2 while c0 is also requesting.
  - Response: c1 wins both accesses before c0.
  - Repeat with LOCK_WB=0 → c0 is served between c1's write and c1's read.
- Timeout: TIMEOUT=8, mem_ready held at 0 → c0_ready pulses with rdata=0 eight cycles after mem_req rises; timeout_err=1 and stays 1 through later successful transfers.
- Reset mid-BUSY: assert rst two cycles into a c1 access → mem_req, grant and c1_ready are 0 immediately (asynchronous); after release, the first contention grants c0.
- Stale-req guard: client read completes with mem_ready held high for 3 cycles → exactly one ready pulse; no second mem_req for the same request.
